// File: rtl/pi_thm_ctrl.sv
// pi_thm_ctrl: drives the phase blender's thermometer select.
// A binary blend code is accepted over a valid/ready handshake and the
// thermometer word is walked toward it one leg at a time, with a settle
// gap after every step, so the blended phase never jumps by more than
// one LSB. All outputs come straight from flops.
module pi_thm_ctrl #(
  parameter int NTHM       = 16,
  parameter int CODE_W     = 5,
  parameter int SETTLE_CYC = 3,
  parameter int INIT_CODE  = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [CODE_W-1:0] code_in,
  input  logic              code_valid,
  output logic              code_ready,
  output logic [NTHM-1:0]   thm_sel_bld,
  output logic [CODE_W-1:0] cur_code,
  output logic              busy,
  output logic              done,
  output logic              sat
);

  // Settle counter only needs to hold SETTLE_CYC; keep at least one bit.
  localparam int CNT_W = (SETTLE_CYC < 2) ? 1 : $clog2(SETTLE_CYC + 1);

  localparam logic [CODE_W-1:0] C_MAX    = CODE_W'(NTHM);
  localparam logic [CODE_W-1:0] C_INIT   = CODE_W'(INIT_CODE);
  localparam logic [CODE_W-1:0] C_ONE    = CODE_W'(1);
  localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(SETTLE_CYC);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_ZERO = {CNT_W{1'b0}};

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STEP   = 2'd1,
    ST_SETTLE = 2'd2
  } state_t;

  // Thermometer encoding: bit i is set when code > i (unsigned, CODE_W wide).
  function automatic logic [NTHM-1:0] f_therm(input logic [CODE_W-1:0] code);
    logic [NTHM-1:0] t;
    t = {NTHM{1'b0}};
    for (int i = 0; i < NTHM; i++) begin
      t[i] = (code > CODE_W'(i));
    end
    return t;
  endfunction

  state_t              r_state;
  logic [CODE_W-1:0]   r_target;
  logic [CODE_W-1:0]   r_cur_code;
  logic [NTHM-1:0]     r_thm;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_ready;
  logic                r_busy;
  logic                r_done;
  logic                r_sat;

  logic                w_accept;
  logic                w_clamp;
  logic [CODE_W-1:0]   w_req_tgt;
  logic                w_up;
  logic [CODE_W-1:0]   w_step_code;
  logic [NTHM-1:0]     w_step_thm;

  // Handshake completes only while idle, since r_ready is set only there.
  assign w_accept    = code_valid & r_ready;
  assign w_clamp     = (code_in > C_MAX);
  assign w_req_tgt   = w_clamp ? C_MAX : code_in;
  assign w_up        = (r_target > r_cur_code);
  assign w_step_code = w_up ? (r_cur_code + C_ONE) : (r_cur_code - C_ONE);
  // A thermometer word moves by one leg with a shift: shifting left with a
  // 1 fills bit cur_code, shifting right with a 0 clears bit cur_code-1.
  assign w_step_thm  = w_up ? {r_thm[NTHM-2:0], 1'b1} : {1'b0, r_thm[NTHM-1:1]};

  // Walk controller: handshake, single-leg steps, settle gaps and flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_target   <= C_INIT;
      r_cur_code <= C_INIT;
      r_thm      <= f_therm(C_INIT);
      r_cnt      <= CNT_ZERO;
      r_ready    <= 1'b1;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_sat      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_target <= w_req_tgt;
            if (w_clamp) begin
              r_sat <= 1'b1;
            end
            if (w_req_tgt == r_cur_code) begin
              // Already there: no step, just acknowledge completion.
              r_done <= 1'b1;
            end else begin
              r_state <= ST_STEP;
              r_ready <= 1'b0;
              r_busy  <= 1'b1;
            end
          end
        end
        ST_STEP: begin
          r_cur_code <= w_step_code;
          r_thm      <= w_step_thm;
          if (SETTLE_CYC > 0) begin
            r_cnt   <= CNT_LOAD;
            r_state <= ST_SETTLE;
          end else if (w_step_code == r_target) begin
            r_state <= ST_IDLE;
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_state <= ST_STEP;
          end
        end
        ST_SETTLE: begin
          r_cnt <= r_cnt - CNT_ONE;
          if (r_cnt == CNT_ONE) begin
            if (r_cur_code == r_target) begin
              r_state <= ST_IDLE;
              r_ready <= 1'b1;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_state <= ST_STEP;
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_ready <= 1'b1;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign code_ready  = r_ready;
  assign thm_sel_bld = r_thm;
  assign cur_code    = r_cur_code;
  assign busy        = r_busy;
  assign done        = r_done;
  assign sat         = r_sat;

endmodule

// File: tb/tb_pi_thm_ctrl.sv
// Bench for pi_thm_ctrl: two instances (settle gap 3 with init code 0, and
// settle gap 0 with init code 4) exercised one at a time. Requests push an
// expected completion into a scoreboard; a monitor pops it on each done.
module tb_pi_thm_ctrl;

  typedef struct {
    int k;
    int code;
    int cyc;
    bit sat;
  } exp_t;

  logic        clk = 1'b0;
  logic [1:0]  rst_v;
  logic [1:0]  valid_v;
  logic [1:0]  rst_d;
  logic [4:0]  code_v [2];

  logic        u0_ready, u0_busy, u0_done, u0_sat;
  logic        u1_ready, u1_busy, u1_done, u1_sat;
  logic [15:0] u0_thm, u1_thm;
  logic [4:0]  u0_cur, u1_cur;

  logic        ready_v [2];
  logic        busy_v  [2];
  logic        done_v  [2];
  logic        sat_v   [2];
  logic [15:0] thm_v   [2];
  logic [4:0]  cur_v   [2];
  logic [15:0] prev_thm [2];

  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;
  int   m_code [2];
  bit   m_sat  [2];
  exp_t sb_q [$];

  pi_thm_ctrl #(.NTHM(16), .CODE_W(5), .SETTLE_CYC(3), .INIT_CODE(0)) u0 (
    .clk(clk), .rst(rst_v[0]), .code_in(code_v[0]), .code_valid(valid_v[0]),
    .code_ready(u0_ready), .thm_sel_bld(u0_thm), .cur_code(u0_cur),
    .busy(u0_busy), .done(u0_done), .sat(u0_sat));

  pi_thm_ctrl #(.NTHM(16), .CODE_W(5), .SETTLE_CYC(0), .INIT_CODE(4)) u1 (
    .clk(clk), .rst(rst_v[1]), .code_in(code_v[1]), .code_valid(valid_v[1]),
    .code_ready(u1_ready), .thm_sel_bld(u1_thm), .cur_code(u1_cur),
    .busy(u1_busy), .done(u1_done), .sat(u1_sat));

  assign ready_v[0] = u0_ready;  assign ready_v[1] = u1_ready;
  assign busy_v[0]  = u0_busy;   assign busy_v[1]  = u1_busy;
  assign done_v[0]  = u0_done;   assign done_v[1]  = u1_done;
  assign sat_v[0]   = u0_sat;    assign sat_v[1]   = u1_sat;
  assign thm_v[0]   = u0_thm;    assign thm_v[1]   = u1_thm;
  assign cur_v[0]   = u0_cur;    assign cur_v[1]   = u1_cur;

  always #5 clk = ~clk;

  function automatic int settle_of(input int k);
    return (k == 0) ? 3 : 0;
  endfunction

  function automatic int init_of(input int k);
    return (k == 0) ? 0 : 4;
  endfunction

  function automatic logic [15:0] therm(input int c);
    return 16'((32'd1 << c) - 32'd1);
  endfunction

  function automatic void chk(input string name, input int k, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s u%0d @cyc %0d: got %0d (0x%0h), expected %0d (0x%0h)",
               name, k, cyc, act, act, exp, exp);
    end
  endfunction

  // Cycle counter and record of whether reset was applied at the last edge.
  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_d <= rst_v;
  end

  // Monitor: invariants every cycle, scoreboard pop on every done pulse.
  always @(negedge clk) begin
    exp_t e;
    for (int k = 0; k < 2; k++) begin
      chk("thermo_invariant", k, thm_v[k], therm(cur_v[k]));
      chk("code_in_range", k, (cur_v[k] <= 5'd16), 1);
      chk("busy_vs_ready", k, busy_v[k], !ready_v[k]);
      if (!rst_d[k]) begin
        chk("one_leg_per_cycle", k, ($countones(thm_v[k] ^ prev_thm[k]) <= 1), 1);
      end
      prev_thm[k] = thm_v[k];
      if (done_v[k] === 1'b1) begin
        if (sb_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL done_spurious u%0d @cyc %0d: done=1, expected no completion", k, cyc);
        end else begin
          e = sb_q.pop_front();
          chk("done_unit", k, k, e.k);
          chk("done_cycle", k, cyc, e.cyc);
          chk("done_code", k, cur_v[k], e.code);
          chk("done_thm", k, thm_v[k], therm(e.code));
          chk("done_sat", k, sat_v[k], e.sat);
        end
      end
    end
  end

  task automatic send(input int k, input int code);
    int   w;
    int   tgt;
    int   d;
    exp_t e;
    w = 0;
    @(negedge clk);
    code_v[k]  = 5'(code);
    valid_v[k] = 1'b1;
    while (ready_v[k] !== 1'b1 && w < 3000) begin
      @(negedge clk);
      w++;
    end
    n_checks++;
    if (ready_v[k] !== 1'b1) begin
      n_errors++;
      $display("FAIL accept_timeout u%0d: ready=%0b after %0d cycles, expected 1", k, ready_v[k], w);
      valid_v[k] = 1'b0;
    end else begin
      tgt = (code > 16) ? 16 : code;
      d   = (tgt > m_code[k]) ? (tgt - m_code[k]) : (m_code[k] - tgt);
      if (code > 16) m_sat[k] = 1'b1;
      e.k    = k;
      e.code = tgt;
      e.cyc  = cyc + 1 + d * (1 + settle_of(k));
      e.sat  = m_sat[k];
      sb_q.push_back(e);
      m_code[k] = tgt;
      @(posedge clk);
      #1;
      valid_v[k] = 1'b0;
    end
  endtask

  task automatic wait_idle(input int k);
    int w;
    w = 0;
    @(negedge clk);
    while ((busy_v[k] !== 1'b0 || sb_q.size() != 0) && w < 3000) begin
      @(negedge clk);
      w++;
    end
    n_checks++;
    if (busy_v[k] !== 1'b0 || sb_q.size() != 0) begin
      n_errors++;
      $display("FAIL idle_timeout u%0d: busy=%0b pending=%0d, expected idle with none pending",
               k, busy_v[k], sb_q.size());
    end
  endtask

  task automatic do_reset(input int k);
    @(negedge clk);
    rst_v[k] = 1'b1;
    sb_q.delete();
    m_code[k] = init_of(k);
    m_sat[k]  = 1'b0;
    @(negedge clk);
    rst_v[k] = 1'b0;
    chk("rst_code", k, cur_v[k], init_of(k));
    chk("rst_thm", k, thm_v[k], therm(init_of(k)));
    chk("rst_ready", k, ready_v[k], 1);
    chk("rst_busy", k, busy_v[k], 0);
    chk("rst_done", k, done_v[k], 0);
    chk("rst_sat", k, sat_v[k], 0);
  endtask

  task automatic mid_walk_reset(input int k, input int from, input int to, input int n);
    int st;
    send(k, from);
    wait_idle(k);
    send(k, to);
    repeat (n) @(negedge clk);
    st = 1 + settle_of(k);
    chk("mid_busy", k, busy_v[k], 1);
    chk("mid_code", k, cur_v[k], from + (n - 1 + st - 1) / st);
    do_reset(k);
  endtask

  task automatic random_run(input int k, input int n);
    int code;
    for (int i = 0; i < n; i++) begin
      code = $urandom_range(0, 20);
      if ($urandom_range(0, 4) == 0) code = m_code[k];
      send(k, code);
      if ($urandom_range(0, 1) == 1) wait_idle(k);
    end
    wait_idle(k);
  endtask

  initial begin
    rst_v     = 2'b11;
    valid_v   = 2'b00;
    code_v[0] = 5'd0;
    code_v[1] = 5'd0;
    for (int k = 0; k < 2; k++) begin
      m_code[k]   = init_of(k);
      m_sat[k]    = 1'b0;
      prev_thm[k] = 16'h0000;
    end
    do_reset(0);
    do_reset(1);

    // Instance 0: settle gap of 3.
    send(0, 5);          wait_idle(0);
    send(0, 16);         wait_idle(0);
    send(0, 0);          wait_idle(0);
    send(0, 20);         wait_idle(0);
    chk("sat_set", 0, sat_v[0], 1);
    send(0, 3);          wait_idle(0);
    chk("sat_sticky", 0, sat_v[0], 1);
    send(0, 7);          wait_idle(0);
    send(0, 7);
    @(negedge clk);
    chk("equal_no_busy", 0, busy_v[0], 0);
    wait_idle(0);
    send(0, 12);
    send(0, 9);          wait_idle(0);
    do_reset(0);
    mid_walk_reset(0, 2, 14, 24);
    random_run(0, 30);

    // Instance 1: no settle gap, nonzero init code.
    send(1, 0);          wait_idle(1);
    send(1, 16);         wait_idle(1);
    send(1, 12);
    send(1, 9);          wait_idle(1);
    mid_walk_reset(1, 2, 14, 6);
    random_run(1, 30);

    chk("scoreboard_empty", 0, sb_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pi_thm_ctrl.md
Name: pi_thm_ctrl

Overview:
- Sequential controller directly upstream of the phase blender; produces its 16-bit thermometer select `thm_sel_bld`.
- Accepts a binary blend code via valid/ready handshake.
- Walks the thermometer word toward the target one bit at a time, with a settle gap between steps, so the blender output never jumps by more than one LSB.
- Registered output only; no combinational path from inputs to `thm_sel_bld`.

Parameters:
- NTHM, 16, thermometer width (number of blender mux legs).
- CODE_W, 5, width of binary code; must satisfy 2**CODE_W > NTHM.
- SETTLE_CYC, 3, idle cycles after each single-bit step (≥0).
- INIT_CODE, 0, code loaded on reset (0..NTHM).

Ports:
- clk  input  1  controller clock
- rst  input  1  synchronous active-high reset
- code_in  input  CODE_W  requested blend code, 0..NTHM
- code_valid  input  1  request strobe
- code_ready  output  1  controller can accept a request
- thm_sel_bld  output  NTHM  thermometer select to blender; bit i = (cur_code > i)
- cur_code  output  CODE_W  binary value currently driven on thm_sel_bld
- busy  output  1  walk in progress (state != IDLE)
- done  output  1  one-cycle pulse when target reached
- sat  output  1  sticky: a request exceeded NTHM and was clamped

Behaviour:
- Reset:
  - `rst` is sampled on `posedge clk`.
  - cur_code = INIT_CODE; thm_sel_bld = thermometer(INIT_CODE); code_ready = 1; busy = 0; done = 0; sat = 0; state = IDLE; settle counter = 0.
  - Reset asserted mid-walk aborts immediately, with no partial step.
- States: IDLE, STEP, SETTLE.
- IDLE:
  - code_ready = 1.
  - On code_valid & code_ready, latch target = min(code_in, NTHM).
  - If code_in > NTHM, set sat (clears only on rst).
  - If target == cur_code: stay IDLE and pulse done next cycle.
  - Otherwise go to STEP.
- STEP (one cycle): code_ready = 0, busy = 1.
  - If target > cur_code: thm_sel_bld[cur_code] <= 1 and cur_code <= cur_code + 1.
  - Else: thm_sel_bld[cur_code-1] <= 0 and cur_code <= cur_code − 1.
  - Exactly one thermometer bit changes per STEP.
  - Next state:
    - SETTLE_CYC > 0: load counter = SETTLE_CYC, go to SETTLE.
    - SETTLE_CYC = 0: compare the updated cur_code with target. If equal, go to IDLE with done pulse; else stay in STEP.
- SETTLE:
  - Decrement counter each cycle.
  - When counter reaches 1: if cur_code == target, go to IDLE and assert done for one cycle; else go to STEP.
- Latency:
  - A request of distance d from cur_code completes in d·(1+SETTLE_CYC) cycles after acceptance.
  - done is asserted in the first IDLE cycle.
- New requests while busy:
  - code_ready = 0, so code_valid is ignored.
  - No queueing; the requester must hold code_valid.
  - The target is not updated mid-walk.
- done and acceptance in the same cycle:
  - done and a new acceptance may coincide (IDLE cycle with code_valid = 1).
  - Both occur.
- Invariants:
  - thm_sel_bld is always a valid thermometer word: contiguous ones from bit 0.
  - thm_sel_bld always equals thermometer(cur_code).
- Range: cur_code never leaves 0..NTHM (boundary codes 0 and NTHM included).
- Width rule: all compares are unsigned, at CODE_W width.

Test Plan:
- Reset with INIT_CODE=0, then code_in=5 → bits 0..4 set in sequence, one per 4 cycles (SETTLE_CYC=3). Completion: cur_code=5, thm_sel_bld=16'h001F, done pulses at cycle 20 after accept.
- From code 16 (16'hFFFF), request 0 → bits clear 15 down to 0, one per step. Final thm_sel_bld=0 and done; thermometer invariant checked every cycle.
- code_in=20 → target clamped to 16, thm_sel_bld=16'hFFFF, sat=1. After a later request of 3, sat stays 1 until rst.
- Request equal to cur_code (7→7) → no bit toggles, busy stays 0, done pulses one cycle after accept.
- Hold code_valid with code_in=9 during a walk to 12 → request ignored until the walk ends. Then accepted in the done cycle; walk reverses to 9.
- Assert rst at the midpoint of a 2→14 walk → next cycle cur_code=INIT_CODE, thm_sel_bld=thermometer(INIT_CODE), IDLE, code_ready=1. Repeat with SETTLE_CYC=0 to verify one step per cycle.
